instr_decode: RTL and testbench

INSTR_DECODE -- requirements
Module: instr_decode

---
 rtl/ecc_isa_pkg.sv | 33 +++
 rtl/loop_tracker.sv | 27 ++
 rtl/instr_decode.sv | 167 ++++++++++++++++
 tb/tb_instr_decode.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ecc_isa_pkg.sv
// Shared ISA definitions for the instruction decoder: opcodes, field layout,
// one-hot FSM encoding and default widths.
package ecc_isa_pkg;

    localparam int unsigned DefIw = 16;
    localparam int unsigned DefAw = 8;
    localparam int unsigned RemW  = 12;

    localparam logic [3:0] OpNop  = 4'h0;
    localparam logic [3:0] OpHalt = 4'hE;
    localparam logic [3:0] OpLoop = 4'hF;

    typedef enum logic [4:0] {
        StIdle = 5'b00001,
        StFill = 5'b00010,
        StRun  = 5'b00100,
        StLoop = 5'b01000,
        StHalt = 5'b10000
    } state_e;

    typedef struct packed {
        logic [3:0] op;
        logic [3:0] f2;
        logic [3:0] f1;
        logic [3:0] f0;
    } instr_t;

    // Cycles spent in the loop state: iterations times body span (255 * 16 fits in 12 bits).
    function automatic logic [RemW-1:0] loop_span(input logic [7:0] cnt1, input logic [3:0] cnt2);
        return {4'b0000, cnt1} * ({8'h00, cnt2} + 12'd1);
    endfunction

endpackage

// File: rtl/loop_tracker.sv
// Remaining-cycle counter for an active loop; flags the final loop cycle.
module loop_tracker
    import ecc_isa_pkg::*;
(
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_load,
    input  logic [RemW-1:0] i_load_val,
    input  logic            i_dec,
    output logic            o_last
);

    logic [RemW-1:0] r_rem;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rem <= '0;
        end else if (i_load) begin
            r_rem <= i_load_val;
        end else if (i_dec && (r_rem != '0)) begin
            r_rem <= r_rem - 12'd1;
        end
    end

    assign o_last = (r_rem == 12'd1);

endmodule

// File: rtl/instr_decode.sv
// Instruction decoder: sequences program start, decodes ROM words into ALU
// operations, loop-load pulses for the program counter, and halt.
module instr_decode
    import ecc_isa_pkg::*;
#(
    parameter int unsigned IW = DefIw,
    parameter int unsigned AW = DefAw
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [AW-1:0] addr,
    output logic [AW-1:0] rom_addr,
    input  logic [IW-1:0] rom_data,
    output logic          pc_enable,
    output logic          loop_enable,
    output logic [7:0]    cnt1,
    output logic [3:0]    cnt2,
    output logic          op_valid,
    output logic [3:0]    opcode,
    output logic [3:0]    dst,
    output logic [3:0]    src_a,
    output logic [3:0]    src_b,
    output logic          done
);

    state_e r_state, w_state_next;

    logic       r_pc_enable, w_pc_enable_next;
    logic       r_loop_enable, w_loop_enable_next;
    logic       r_op_valid, w_op_valid_next;
    logic       r_done, w_done_next;
    logic [7:0] r_cnt1, w_cnt1_next;
    logic [3:0] r_cnt2, w_cnt2_next;
    logic [3:0] r_opcode, w_opcode_next;
    logic [3:0] r_dst, w_dst_next;
    logic [3:0] r_src_a, w_src_a_next;
    logic [3:0] r_src_b, w_src_b_next;

    instr_t          w_instr;
    logic            w_is_alu;
    logic            w_loop_go;
    logic            w_rem_load;
    logic            w_rem_dec;
    logic            w_rem_last;
    logic [RemW-1:0] w_rem_val;

    assign rom_addr  = addr;
    assign w_instr   = rom_data[15:0];
    assign w_is_alu  = (w_instr.op != OpNop) && (w_instr.op != OpHalt) && (w_instr.op != OpLoop);
    assign w_loop_go = (w_instr.op == OpLoop) && ({w_instr.f1, w_instr.f0} != 8'h00);
    assign w_rem_val = loop_span({w_instr.f1, w_instr.f0}, w_instr.f2);

    loop_tracker u_loop_tracker (
        .i_clk      (clk),
        .i_rst_n    (rst),
        .i_load     (w_rem_load),
        .i_load_val (w_rem_val),
        .i_dec      (w_rem_dec),
        .o_last     (w_rem_last)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next       = r_state;
        w_pc_enable_next   = 1'b0;
        w_loop_enable_next = 1'b0;
        w_op_valid_next    = 1'b0;
        w_done_next        = r_done;
        w_cnt1_next        = r_cnt1;
        w_cnt2_next        = r_cnt2;
        w_opcode_next      = r_opcode;
        w_dst_next         = r_dst;
        w_src_a_next       = r_src_a;
        w_src_b_next       = r_src_b;
        w_rem_load         = 1'b0;
        w_rem_dec          = 1'b0;

        unique case (r_state)
            StIdle: begin
                if (start) begin
                    w_pc_enable_next = 1'b1;
                    w_state_next     = StFill;
                end
            end
            StFill: begin
                w_state_next = StRun;
            end
            StRun, StLoop: begin
                if (r_state == StLoop) begin
                    w_rem_dec = 1'b1;
                    if (w_rem_last) begin
                        w_state_next = StRun;
                    end
                end
                // Halt overrides loop exit; nested loops decode as NOP.
                if (w_instr.op == OpHalt) begin
                    w_state_next = StHalt;
                    w_done_next  = 1'b1;
                end else if (w_is_alu) begin
                    w_op_valid_next = 1'b1;
                    w_opcode_next   = w_instr.op;
                    w_dst_next      = w_instr.f2;
                    w_src_a_next    = w_instr.f1;
                    w_src_b_next    = w_instr.f0;
                end else if (w_loop_go && (r_state == StRun)) begin
                    w_loop_enable_next = 1'b1;
                    w_cnt1_next        = {w_instr.f1, w_instr.f0};
                    w_cnt2_next        = w_instr.f2;
                    w_rem_load         = 1'b1;
                    w_state_next       = StLoop;
                end
            end
            StHalt: begin
                w_done_next = 1'b1;
            end
            default: begin
                w_state_next = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pc_enable   <= 1'b0;
            r_loop_enable <= 1'b0;
            r_op_valid    <= 1'b0;
            r_done        <= 1'b0;
            r_cnt1        <= '0;
            r_cnt2        <= '0;
            r_opcode      <= '0;
            r_dst         <= '0;
            r_src_a       <= '0;
            r_src_b       <= '0;
        end else begin
            r_pc_enable   <= w_pc_enable_next;
            r_loop_enable <= w_loop_enable_next;
            r_op_valid    <= w_op_valid_next;
            r_done        <= w_done_next;
            r_cnt1        <= w_cnt1_next;
            r_cnt2        <= w_cnt2_next;
            r_opcode      <= w_opcode_next;
            r_dst         <= w_dst_next;
            r_src_a       <= w_src_a_next;
            r_src_b       <= w_src_b_next;
        end
    end

    assign pc_enable   = r_pc_enable;
    assign loop_enable = r_loop_enable;
    assign op_valid    = r_op_valid;
    assign done        = r_done;
    assign cnt1        = r_cnt1;
    assign cnt2        = r_cnt2;
    assign opcode      = r_opcode;
    assign dst         = r_dst;
    assign src_a       = r_src_a;
    assign src_b       = r_src_b;

endmodule

// File: tb/tb_instr_decode.sv
// Scoreboard bench for instr_decode: an instruction-level program model predicts
// output events; a negedge monitor pops and compares them as the DUT emits them.
module tb_instr_decode;
    import ecc_isa_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  addr = '0;
    logic [15:0] rom_data = '0;
    logic [7:0]  rom_addr;
    logic        pc_enable, loop_enable, op_valid, done;
    logic [7:0]  cnt1;
    logic [3:0]  cnt2, opcode, dst, src_a, src_b;

    instr_decode #(.IW(16), .AW(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .addr        (addr),
        .rom_addr    (rom_addr),
        .rom_data    (rom_data),
        .pc_enable   (pc_enable),
        .loop_enable (loop_enable),
        .cnt1        (cnt1),
        .cnt2        (cnt2),
        .op_valid    (op_valid),
        .opcode      (opcode),
        .dst         (dst),
        .src_a       (src_a),
        .src_b       (src_b),
        .done        (done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         stamp;
        bit         is_loop;
        logic [3:0] opc, d, sa, sb;
        logic [7:0] c1;
        logic [3:0] c2;
    } ev_t;

    localparam int PhIdle = 0, PhFill = 1, PhRun = 2, PhHalt = 3;

    ev_t exp_q[$];
    int  n_checks = 0;
    int  n_fail = 0;
    int  phase = PhIdle;
    int  loop_left = 0;
    int  pc_cyc = -1;
    int  halt_cyc = -1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Monitor: per-cycle level checks plus event scoreboard.
    always @(negedge clk) begin : monitor
        ev_t e;
        if (rst) begin
            check("rom_addr", rom_addr, addr);
            check("pulse_exclusive", op_valid && loop_enable, 0);
            check("pc_enable", pc_enable, cyc == pc_cyc);
            check("done", done, (halt_cyc >= 0) && (cyc >= halt_cyc));
            while (exp_q.size() > 0 && exp_q[0].stamp < cyc) begin
                n_checks++;
                n_fail++;
                $display("FAIL missing_output: got none expected event for cycle %0d", exp_q[0].stamp);
                void'(exp_q.pop_front());
            end
            if (op_valid || loop_enable) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_output: got op_valid=%0b loop_enable=%0b expected none (cycle %0d)",
                             op_valid, loop_enable, cyc);
                end else begin
                    e = exp_q.pop_front();
                    check("event_cycle", cyc, e.stamp);
                    check("loop_enable", loop_enable, e.is_loop);
                    check("op_valid", op_valid, !e.is_loop);
                    if (e.is_loop) begin
                        check("cnt1", cnt1, e.c1);
                        check("cnt2", cnt2, e.c2);
                    end else begin
                        check("opcode", opcode, e.opc);
                        check("dst", dst, e.d);
                        check("src_a", src_a, e.sa);
                        check("src_b", src_b, e.sb);
                    end
                end
            end
        end
    end

    // Present one ROM word (sampled at the next rising edge) and advance the program model.
    task automatic drive(input logic [15:0] w, input logic st);
        int   new_left;
        bit   in_loop;
        ev_t  e;
        logic [3:0] op;
        @(negedge clk);
        rom_data = w;
        start    = st;
        addr     = 8'($urandom);
        op       = w[15:12];
        new_left = 0;
        in_loop  = (loop_left > 0);
        e.stamp  = cyc + 1;
        case (phase)
            PhIdle: if (st) begin
                pc_cyc = cyc + 1;
                phase  = PhFill;
            end
            PhFill: phase = PhRun;
            PhRun: begin
                if (op == OpHalt) begin
                    halt_cyc = cyc + 1;
                    phase    = PhHalt;
                end else if (op == OpLoop) begin
                    if (!in_loop && w[7:0] != 8'h00) begin
                        e.is_loop = 1'b1;
                        e.c1 = w[7:0];
                        e.c2 = w[11:8];
                        exp_q.push_back(e);
                        new_left = int'(w[7:0]) * (int'(w[11:8]) + 1);
                    end
                end else if (op != OpNop) begin
                    e.is_loop = 1'b0;
                    e.opc = op;
                    e.d   = w[11:8];
                    e.sa  = w[7:4];
                    e.sb  = w[3:0];
                    exp_q.push_back(e);
                end
                if (in_loop) loop_left--;
                if (new_left > 0) loop_left = new_left;
            end
            default: ;
        endcase
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2;
        rst = 1'b0;
        start = 1'b0;
        rom_data = '0;
        #1;
        check("rst_pc_enable", pc_enable, 0);
        check("rst_loop_enable", loop_enable, 0);
        check("rst_op_valid", op_valid, 0);
        check("rst_done", done, 0);
        check("rst_cnt1", cnt1, 0);
        check("rst_cnt2", cnt2, 0);
        check("rst_opcode", opcode, 0);
        check("rst_dst", dst, 0);
        check("rst_src_a", src_a, 0);
        check("rst_src_b", src_b, 0);
        exp_q.delete();
        phase = PhIdle;
        loop_left = 0;
        pc_cyc = -1;
        halt_cyc = -1;
        @(negedge clk);
        rst = 1'b1;
    endtask

    function automatic logic [15:0] rand_word();
        int r;
        r = $urandom_range(0, 99);
        if (r < 12)      return {OpNop, 12'($urandom)};
        else if (r < 14) return {OpHalt, 12'($urandom)};
        else if (r < 30) return {OpLoop, 4'($urandom_range(0, 3)), 8'($urandom_range(0, 5))};
        else             return {4'($urandom_range(1, 13)), 12'($urandom)};
    endfunction

    initial begin
        do_reset();
        // Words and no start while idle are ignored.
        drive(16'h1234, 1'b0);
        drive(16'hF203, 1'b0);
        drive(16'h0000, 1'b1);          // start
        drive(16'h5678, 1'b0);          // fill word, ignored
        drive(16'h1234, 1'b0);          // ALU op
        drive(16'h0000, 1'b1);          // NOP, start ignored
        drive(16'hF203, 1'b0);          // loop of 9 cycles
        drive(16'hF101, 1'b0);          // nested loop ignored
        for (int i = 0; i < 7; i++) drive({4'($urandom_range(1, 13)), 12'($urandom)}, 1'b0);
        drive(16'hF101, 1'b0);          // last loop cycle, still ignored
        drive(16'hF500, 1'b0);          // zero-count loop behaves as NOP
        drive(16'hF101, 1'b0);          // 2-cycle loop
        drive(16'h2345, 1'b0);
        drive(16'hE000, 1'b0);          // halt on final loop cycle
        drive(16'h1234, 1'b1);
        drive(16'hF203, 1'b0);
        for (int i = 0; i < 4; i++) drive(16'h9ABC, 1'b1);

        // Reset in the middle of a loop.
        do_reset();
        drive(16'h0000, 1'b1);
        drive(16'h0000, 1'b0);
        drive(16'hF203, 1'b0);
        drive(16'h3111, 1'b0);
        drive(16'h0000, 1'b0);
        do_reset();
        drive(16'h1234, 1'b0);
        drive(16'h0000, 1'b0);
        drive(16'h0000, 1'b1);
        drive(16'h0000, 1'b0);
        drive(16'h1234, 1'b0);
        drive(16'hE000, 1'b0);
        drive(16'h0000, 1'b0);

        // Randomized programs.
        for (int round = 0; round < 6; round++) begin
            do_reset();
            drive(16'h0000, 1'b1);
            drive(rand_word(), 1'b0);
            for (int i = 0; i < 150; i++) drive(rand_word(), ($urandom_range(0, 19) == 0));
        end

        drive(16'h0000, 1'b0);
        drive(16'h0000, 1'b0);
        @(negedge clk);
        check("queue_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
